// File: rtl/data_interleaver_pkg.sv
// Shared 802.11a interleaver constants: rate codes, block sizes and frame modes.
// Used by both the transmit interleaver and the receive deinterleaver.
package data_interleaver_pkg;

    localparam logic [3:0] RATE_BPSK  = 4'b1101;
    localparam logic [3:0] RATE_QPSK  = 4'b0101;
    localparam logic [3:0] RATE_16QAM = 4'b1001;

    localparam int NCBPS_BPSK  = 48;
    localparam int NCBPS_QPSK  = 96;
    localparam int NCBPS_16QAM = 192;

    localparam logic [3:0] NB_BPSK  = 4'(NCBPS_BPSK / 16);
    localparam logic [3:0] NB_QPSK  = 4'(NCBPS_QPSK / 16);
    localparam logic [3:0] NB_16QAM = 4'(NCBPS_16QAM / 16);

    localparam logic MODE_SIGNAL = 1'b0;
    localparam logic MODE_DATA   = 1'b1;

    // Columns per block (N_CBPS/16) for a DATA symbol; unknown codes fall back to BPSK.
    function automatic logic [3:0] nb_of_rate(input logic [3:0] rate);
        case (rate)
            RATE_QPSK:  nb_of_rate = NB_QPSK;
            RATE_16QAM: nb_of_rate = NB_16QAM;
            RATE_BPSK:  nb_of_rate = NB_BPSK;
            default:    nb_of_rate = NB_BPSK;
        endcase
    endfunction

endpackage

// File: rtl/data_interleaver_addr.sv
// Interleaver buffer address from read counters (r, c); combinational.
// 16-QAM swaps the LSB pair of adjacent rows (s=2), otherwise a plain 16-column transpose.
module interleave_addr (
    input  logic [3:0] i_r,
    input  logic [3:0] i_c,
    input  logic       i_qam,
    output logic [7:0] o_addr
);

    assign o_addr = i_qam ? {i_r[3:1], i_r[0] ^ i_c[0], i_c} : {i_r, i_c};

endmodule

// File: rtl/data_interleaver.sv
// 802.11a transmit block interleaver, ping-pong 2x192-bit buffers, natural-order write, permuted serial read.
// First output bit one cycle after a block's last input bit; no backpressure, input never exceeds 1 bit/cycle.
module data_interleaver
    import data_interleaver_pkg::*;
(
    input  logic       Clk,
    input  logic       reset,
    input  logic [3:0] rate,
    input  logic       in,
    input  logic       in_valid,
    input  logic       in_start,
    output logic       out,
    output logic       out_valid,
    output logic       out_first
);

    localparam logic [1:0] WR_IDLE   = 2'b00;
    localparam logic [1:0] WR_SIGNAL = {1'b1, MODE_SIGNAL};
    localparam logic [1:0] WR_DATA   = {1'b1, MODE_DATA};
    localparam logic       RD_IDLE   = 1'b0;
    localparam logic       RD_SEND   = 1'b1;

    logic [191:0] r_buf [2];

    logic [1:0]   r_wr_state;
    logic [7:0]   r_k;
    logic         r_wr_sel;
    logic [3:0]   r_wr_nb;

    logic         r_pend;
    logic         r_pend_sel;
    logic [3:0]   r_pend_nb;

    logic         r_rd_state;
    logic         r_rd_sel;
    logic [3:0]   r_rd_nb;
    logic [3:0]   r_rd_r;
    logic [3:0]   r_rd_c;

    logic [3:0]   w_nb;
    logic [7:0]   w_last_k;
    logic         w_wr_en;
    logic [7:0]   w_wr_addr;
    logic         w_hand;
    logic         w_rd_last;
    logic         w_rd_load;
    logic         w_rd_qam;
    logic [7:0]   w_rd_addr;
    logic         w_rd_bit;

    // The DATA block size comes straight from rate on its first bit, from the latch afterwards.
    assign w_nb      = (r_wr_state == WR_DATA && r_k == 8'd0) ? nb_of_rate(rate) : r_wr_nb;
    assign w_last_k  = {w_nb, 4'b0000} - 8'd1;
    assign w_wr_en   = in_valid && (in_start || r_wr_state != WR_IDLE);
    assign w_wr_addr = in_start ? 8'd0 : r_k;
    assign w_hand    = in_valid && !in_start && (r_wr_state != WR_IDLE) && (r_k == w_last_k);

    always_ff @(posedge Clk) begin
        if (w_wr_en) begin
            r_buf[r_wr_sel][w_wr_addr] <= in;
        end
    end

    always_ff @(posedge Clk or negedge reset) begin
        if (!reset) begin
            r_wr_state <= WR_IDLE;
            r_k        <= 8'd0;
            r_wr_sel   <= 1'b0;
            r_wr_nb    <= NB_BPSK;
        end else if (in_valid) begin
            if (in_start) begin
                r_wr_state <= WR_SIGNAL;
                r_k        <= 8'd1;
                r_wr_nb    <= NB_BPSK;
            end else if (r_wr_state != WR_IDLE) begin
                if (r_wr_state == WR_DATA && r_k == 8'd0) begin
                    r_wr_nb <= w_nb;
                end
                if (w_hand) begin
                    r_k        <= 8'd0;
                    r_wr_sel   <= ~r_wr_sel;
                    r_wr_state <= WR_DATA;
                end else begin
                    r_k <= r_k + 8'd1;
                end
            end
        end
    end

    always_ff @(posedge Clk or negedge reset) begin
        if (!reset) begin
            r_pend     <= 1'b0;
            r_pend_sel <= 1'b0;
            r_pend_nb  <= 4'd0;
        end else if (w_hand) begin
            r_pend     <= 1'b1;
            r_pend_sel <= r_wr_sel;
            r_pend_nb  <= w_nb;
        end else if (w_rd_load) begin
            r_pend <= 1'b0;
        end
    end

    assign w_rd_last = (r_rd_state == RD_SEND) && (r_rd_r == r_rd_nb - 4'd1) && (r_rd_c == 4'd15);
    assign w_rd_load = r_pend && (r_rd_state == RD_IDLE || w_rd_last);

    // A pending block is picked up on the cycle after the last bit, keeping the output gap-free.
    always_ff @(posedge Clk or negedge reset) begin
        if (!reset) begin
            r_rd_state <= RD_IDLE;
            r_rd_sel   <= 1'b0;
            r_rd_nb    <= 4'd0;
            r_rd_r     <= 4'd0;
            r_rd_c     <= 4'd0;
        end else if (w_rd_load) begin
            r_rd_state <= RD_SEND;
            r_rd_sel   <= r_pend_sel;
            r_rd_nb    <= r_pend_nb;
            r_rd_r     <= 4'd0;
            r_rd_c     <= 4'd0;
        end else if (r_rd_state == RD_SEND) begin
            if (w_rd_last) begin
                r_rd_state <= RD_IDLE;
                r_rd_r     <= 4'd0;
                r_rd_c     <= 4'd0;
            end else if (r_rd_r == r_rd_nb - 4'd1) begin
                r_rd_r <= 4'd0;
                r_rd_c <= r_rd_c + 4'd1;
            end else begin
                r_rd_r <= r_rd_r + 4'd1;
            end
        end
    end

    assign w_rd_qam = (r_rd_nb == NB_16QAM);

    interleave_addr u_addr (
        .i_r    (r_rd_r),
        .i_c    (r_rd_c),
        .i_qam  (w_rd_qam),
        .o_addr (w_rd_addr)
    );

    assign w_rd_bit  = r_buf[r_rd_sel][w_rd_addr];
    assign out_valid = (r_rd_state == RD_SEND);
    assign out       = out_valid & w_rd_bit;
    assign out_first = out_valid && (r_rd_r == 4'd0) && (r_rd_c == 4'd0);

endmodule

// File: tb/tb_data_interleaver.sv
// Scoreboard bench for data_interleaver: expected bits (with due cycle) are queued when a block
// completes and checked against the serial output on the falling edge.
module tb_data_interleaver;

    localparam logic [3:0] C_QPSK  = 4'b0101;
    localparam logic [3:0] C_16QAM = 4'b1001;
    localparam logic [3:0] C_BPSK  = 4'b1101;

    logic       Clk;
    logic       reset;
    logic [3:0] rate;
    logic       in;
    logic       in_valid;
    logic       in_start;
    logic       out;
    logic       out_valid;
    logic       out_first;

    typedef struct {
        int val;
        int first;
        int due;
    } exp_t;

    exp_t sb[$];
    int   cyc     = 0;
    int   n_tests = 0;
    int   n_fail  = 0;

    data_interleaver dut (
        .Clk       (Clk),
        .reset     (reset),
        .rate      (rate),
        .in        (in),
        .in_valid  (in_valid),
        .in_start  (in_start),
        .out       (out),
        .out_valid (out_valid),
        .out_first (out_first)
    );

    initial begin
        Clk = 1'b0;
        forever #5 Clk = ~Clk;
    end

    always @(posedge Clk) cyc <= cyc + 1;

    task automatic chk(input string tag, input int got, input int exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    // Standard 802.11a two-step permutation: input index k lands at output position j.
    function automatic int perm(input int k, input int n, input int s);
        int i;
        i = (n / 16) * (k % 16) + k / 16;
        return s * (i / s) + (i + n - (16 * i) / n) % s;
    endfunction

    always @(negedge Clk) begin
        exp_t e;
        if (out_valid) begin
            if (sb.size() == 0) begin
                chk("spurious_valid", 1, 0);
            end else begin
                e = sb.pop_front();
                chk("out_cycle", cyc, e.due);
                chk("out_bit", int'(out), e.val);
                chk("out_first", int'(out_first), e.first);
            end
        end else begin
            if (out_first) chk("first_without_valid", 1, 0);
            if (sb.size() > 0 && sb[0].due <= cyc) begin
                chk("missing_out", 0, 1);
                e = sb.pop_front();
            end
        end
    end

    task automatic drive_bit(input logic b, input logic st, input logic [3:0] rt);
        in       = b;
        in_start = st;
        rate     = rt;
        in_valid = 1'b1;
        @(posedge Clk);
        #1;
    endtask

    task automatic idle(input int n);
        in_valid = 1'b0;
        in_start = 1'b0;
        repeat (n) begin
            @(posedge Clk);
            #1;
        end
    endtask

    task automatic ignore_bits(input int n);
        for (int i = 0; i < n; i++) drive_bit(1'($urandom_range(1)), 1'b0, C_16QAM);
        in_valid = 1'b0;
    endtask

    // is_sig: SIGNAL block (BPSK, rate ignored); onehot<0 gives random data; trunc>=0 stops early.
    task automatic send_block(input bit is_sig, input logic [3:0] rt, input int onehot, input int trunc);
        int   n, s, nbits, t;
        int   b[192];
        int   o[192];
        exp_t e;
        n = 48;
        s = 1;
        if (!is_sig && rt == C_QPSK) n = 96;
        if (!is_sig && rt == C_16QAM) begin
            n = 192;
            s = 2;
        end
        for (int k = 0; k < n; k++) b[k] = (onehot >= 0) ? int'(k == onehot) : int'($urandom_range(1));
        nbits = (trunc >= 0) ? trunc : n;
        for (int k = 0; k < nbits; k++) begin
            if (is_sig)
                drive_bit(1'(b[k]), k == 0, C_16QAM);
            else
                drive_bit(1'(b[k]), 1'b0, (k == 0) ? rt : (rt ^ 4'b1100));
        end
        in_valid = 1'b0;
        in_start = 1'b0;
        if (trunc < 0) begin
            t = cyc;
            for (int k = 0; k < n; k++) o[perm(k, n, s)] = b[k];
            for (int j = 0; j < n; j++) begin
                e.val   = o[j];
                e.first = int'(j == 0);
                e.due   = t + 1 + j;
                sb.push_back(e);
            end
        end
    endtask

    initial begin
        reset    = 1'b0;
        rate     = 4'd0;
        in       = 1'b0;
        in_valid = 1'b0;
        in_start = 1'b0;
        repeat (3) @(posedge Clk);
        #1;
        chk("reset_out", int'(out), 0);
        chk("reset_out_valid", int'(out_valid), 0);
        chk("reset_out_first", int'(out_first), 0);
        reset = 1'b1;
        idle(2);

        ignore_bits(30);
        idle(10);

        send_block(1, C_BPSK, 1, -1);
        idle(60);

        send_block(1, C_BPSK, -1, -1);
        send_block(0, C_QPSK, 17, -1);
        idle(110);

        send_block(1, C_BPSK, -1, -1);
        send_block(0, C_16QAM, 16, -1);
        send_block(0, C_16QAM, 17, -1);
        idle(210);

        send_block(1, C_BPSK, -1, -1);
        for (int i = 0; i < 3; i++) send_block(0, C_BPSK, -1, -1);
        send_block(0, C_16QAM, -1, -1);
        send_block(0, C_16QAM, -1, -1);
        idle(210);

        send_block(1, C_BPSK, -1, -1);
        send_block(0, C_BPSK, -1, -1);
        send_block(0, C_QPSK, -1, 40);
        send_block(1, C_BPSK, -1, -1);
        idle(60);

        send_block(1, C_BPSK, -1, -1);
        send_block(0, C_16QAM, -1, -1);
        idle(50);
        chk("pre_reset_valid", int'(out_valid), 1);
        reset = 1'b0;
        #1;
        chk("mid_reset_out", int'(out), 0);
        chk("mid_reset_out_valid", int'(out_valid), 0);
        chk("mid_reset_out_first", int'(out_first), 0);
        sb.delete();
        @(posedge Clk);
        #1;
        @(posedge Clk);
        #3;
        reset = 1'b1;
        @(posedge Clk);
        #1;
        ignore_bits(30);
        idle(20);
        send_block(1, C_BPSK, -1, -1);
        idle(60);

        for (int i = 0; i < 1000 && sb.size() > 0; i++) @(posedge Clk);
        #1;
        chk("drain_empty", sb.size(), 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
